// File: rtl/cpu_defs.sv
// Shared CPU front-end types: fetch pass records, exception record, redirect/BTB requests.
// Latency: none (type and constant definitions only).
// Backpressure: n/a.
package cpu_defs;

    typedef logic [31:0] u32_t;
    typedef logic [31:0] virt_t;

    localparam logic [5:0] ECODE_ADEF       = 6'h08;
    localparam virt_t      RESET_PC_DEFAULT = 32'h1c00_0000;

    typedef struct packed {
        virt_t pc;
        logic  is_predict;
    } next_pc_t;

    typedef struct packed {
        logic     valid;
        virt_t    pc;
        next_pc_t next;
        logic     icache_wait_resp;
    } fetch1_fetch2_pass_t;

    typedef struct packed {
        logic       valid;
        logic [5:0] ecode;
        logic [8:0] esubcode;
    } excp_pass_t;

    typedef struct packed {
        logic  valid;
        virt_t pc;
    } wr_pc_req_t;

    typedef struct packed {
        logic  valid;
        virt_t pc;
    } btb_invalid_t;

endpackage

// File: rtl/btb_dm.sv
// Direct-mapped branch target buffer indexed by word address; combinational lookup.
// Latency: lookup 0 cycles; update/invalidate visible to lookups the following cycle.
// Backpressure: none, every update/invalidate is accepted in the cycle presented.
import cpu_defs::*;

module btb_dm #(
    parameter int ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] i_lookup_wa,
    output logic        o_hit,
    output virt_t       o_target,
    input  logic        i_upd_vld,
    input  logic [29:0] i_upd_wa,
    input  virt_t       i_upd_target,
    input  logic        i_inv_vld,
    input  logic [29:0] i_inv_wa
);
    localparam int IDX = $clog2(ENTRIES);
    localparam int TW  = 30 - IDX;

    logic [ENTRIES-1:0] r_valid;
    logic [TW-1:0]      r_tag    [ENTRIES];
    virt_t              r_target [ENTRIES];

    logic [IDX-1:0] w_lk_idx, w_upd_idx, w_inv_idx;
    logic [TW-1:0]  w_lk_tag, w_upd_tag, w_inv_tag;
    logic           w_inv_hit;

    assign w_lk_idx  = i_lookup_wa[IDX-1:0];
    assign w_lk_tag  = i_lookup_wa[29:IDX];
    assign w_upd_idx = i_upd_wa[IDX-1:0];
    assign w_upd_tag = i_upd_wa[29:IDX];
    assign w_inv_idx = i_inv_wa[IDX-1:0];
    assign w_inv_tag = i_inv_wa[29:IDX];

    assign o_hit    = r_valid[w_lk_idx] & (r_tag[w_lk_idx] == w_lk_tag);
    assign o_target = r_target[w_lk_idx];

    // An invalidate hitting the slot being updated this cycle always wins,
    // otherwise it only kills an entry whose stored tag matches.
    assign w_inv_hit = i_inv_vld &
                       ((i_upd_vld & (w_upd_idx == w_inv_idx)) | (r_tag[w_inv_idx] == w_inv_tag));

    // Valid bits: set on update, cleared by a matching invalidate (later assignment wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else begin
            if (i_upd_vld) r_valid[w_upd_idx] <= 1'b1;
            if (w_inv_hit) r_valid[w_inv_idx] <= 1'b0;
        end
    end

    // Tag/target payload needs no reset; it is qualified by the valid bit.
    always_ff @(posedge clk) begin
        if (i_upd_vld) begin
            r_tag[w_upd_idx]    <= w_upd_tag;
            r_target[w_upd_idx] <= i_upd_target;
        end
    end

endmodule

// File: rtl/fetch1_stage.sv
// Fetch stage 1: owns fetch PC, applies redirects, BTB predict (FETCH1_BTB_EN), issues icache request.
// Latency: 1 cycle from icache request to registered fetch1->fetch2 pass record.
// Backpressure: stall_i or icache not ready holds PC; redirects/flush insert a one-cycle bubble.
import cpu_defs::*;

module fetch1_stage #(
    parameter virt_t RESET_PC    = RESET_PC_DEFAULT,
    parameter int    BTB_ENTRIES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic                be_wr_pc_valid,
    input  logic [31:0]         be_wr_pc,
    input  logic                f2_wr_pc_valid,
    input  logic [31:0]         f2_wr_pc,
    input  logic                f2_wr_pc_is_predict,
    input  logic                btb_inv_valid,
    input  logic [31:0]         btb_inv_pc,
    input  logic                btb_upd_valid,
    input  logic [31:0]         btb_upd_pc,
    input  logic [31:0]         btb_upd_target,
    output logic                icache_req_valid,
    output logic [31:0]         icache_req_addr,
    input  logic                icache_req_ready,
    output fetch1_fetch2_pass_t pass_out,
    output excp_pass_t          excp_pass_out
);
    virt_t               r_pc;
    logic                r_started;
    fetch1_fetch2_pass_t r_pass;
    excp_pass_t          r_excp;

    logic     w_misaligned, w_redirect, w_advance, w_accept, w_load, w_rec_vld;
    logic     w_btb_hit;
    virt_t    w_btb_target;
    next_pc_t w_next;

`ifdef FETCH1_BTB_EN
    logic w_unused_ok;
    assign w_unused_ok = ^{btb_upd_pc[1:0], btb_inv_pc[1:0]};

    btb_dm #(.ENTRIES(BTB_ENTRIES)) u_btb (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_lookup_wa  (r_pc[31:2]),
        .o_hit        (w_btb_hit),
        .o_target     (w_btb_target),
        .i_upd_vld    (btb_upd_valid),
        .i_upd_wa     (btb_upd_pc[31:2]),
        .i_upd_target (btb_upd_target),
        .i_inv_vld    (btb_inv_valid),
        .i_inv_wa     (btb_inv_pc[31:2])
    );
`else
    localparam int unused_btb_entries = BTB_ENTRIES;
    logic w_unused_ok;
    assign w_unused_ok  = ^{btb_inv_valid, btb_inv_pc, btb_upd_valid, btb_upd_pc, btb_upd_target};
    assign w_btb_hit    = 1'b0;
    assign w_btb_target = '0;
`endif

    assign w_misaligned = |r_pc[1:0];
    assign w_redirect   = be_wr_pc_valid | f2_wr_pc_valid;
    // Nothing moves before the first request slot, so the reset PC is never skipped.
    assign w_advance    = r_started & ~stall_i & (icache_req_ready | w_misaligned);

    assign icache_req_valid = r_started & ~stall_i & ~w_misaligned & ~w_redirect;
    assign icache_req_addr  = r_pc;
    assign w_accept         = icache_req_valid & icache_req_ready;

    // A not-ready icache still pushes a bubble downstream when fetch2 is free.
    assign w_load    = flush_i | ~stall_i;
    assign w_rec_vld = w_advance & ~w_redirect & ~flush_i & (w_accept | w_misaligned);

    // Next-PC selection: backend, fetch2, BTB hit (aligned PCs only), sequential.
    always_comb begin
        w_next.pc         = r_pc + 32'd4;
        w_next.is_predict = 1'b0;
        if (be_wr_pc_valid) begin
            w_next.pc = be_wr_pc;
        end else if (f2_wr_pc_valid) begin
            w_next.pc         = f2_wr_pc;
            w_next.is_predict = f2_wr_pc_is_predict;
        end else if (w_btb_hit && !w_misaligned) begin
            w_next.pc         = w_btb_target;
            w_next.is_predict = 1'b1;
        end
    end

    // Fetch PC and start flag; redirects land even while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_started <= 1'b0;
        end else begin
            r_started <= 1'b1;
            if (w_redirect || w_advance) r_pc <= w_next.pc;
        end
    end

    // Pass and exception records register together; a dropped record drops its exception.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass <= '0;
            r_excp <= '0;
        end else if (w_load) begin
            r_pass.valid            <= w_rec_vld;
            r_pass.pc               <= r_pc;
            r_pass.next             <= w_next;
            r_pass.icache_wait_resp <= w_accept;
            r_excp.valid            <= w_rec_vld & w_misaligned;
            r_excp.ecode            <= ECODE_ADEF;
            r_excp.esubcode         <= '0;
        end
    end

    assign pass_out      = r_pass;
    assign excp_pass_out = r_excp;

endmodule
